genbuf_fifo: RTL and testbench
==============================

GENBUF_FIFO -- requirements
Module: genbuf_fifo

Interface
REQ-001 Parameter DATA_W, default 32, is the width of one buffered word.
REQ-002 Parameter DEPTH_LOG2, default 2, sets the FIFO depth to DEPTH = 2^DEPTH_LOG2 entries.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ENQ_p  input  1  enqueue request; writes DI_p this cycle.
REQ-006 DEQ_p  input  1  dequeue request; pops the head entry this cycle.
REQ-007 DI_p  input  DATA_W  write data, sampled when an enqueue is accepted.
REQ-008 DO_p  output  DATA_W  head-of-queue data, first-word fall-through.
REQ-009 EMPTY_p  output  1  high when occupancy is 0; consumed by the receiver-side controller and the G12 monitor.
REQ-010 FULL_p  output  1  high when occupancy equals DEPTH.
REQ-011 COUNT_p  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-012 OVF_p, UNF_p  output  1 each  sticky overflow/underflow flags; present only under GENBUF_FIFO_ERR_EN.

Function
REQ-013 State: DEPTH x DATA_W storage array, write pointer wp, read pointer rp (DEPTH_LOG2 bits each), occupancy counter cnt (DEPTH_LOG2+1 bits).
REQ-014 Accepted enqueue: enq_ok = ENQ_p && (!FULL_p || DEQ_p); stores DI_p at mem[wp]; wp increments.
REQ-015 Accepted dequeue: deq_ok = DEQ_p && !EMPTY_p; rp increments.
REQ-016 Pointers wrap modulo DEPTH; DEPTH-1 + 1 -> 0 with no gap cycle.
REQ-017 cnt update: +1 on enq_ok only; -1 on deq_ok only; unchanged when both or neither occur.
REQ-018 EMPTY_p, FULL_p and COUNT_p are registered and reflect cnt after the edge; no combinational path from ENQ_p/DEQ_p to them.
REQ-019 DO_p = mem[rp] combinationally from the registered rp; the value is meaningful only while EMPTY_p=0.
REQ-020 Write latency: a word enqueued into an empty FIFO appears on DO_p, with EMPTY_p=0, in the next cycle.
REQ-021 No bypass: ENQ_p and DEQ_p together while empty perform the enqueue only; EMPTY_p=1 then returns 0 next cycle.
REQ-022 ENQ_p and DEQ_p together while full perform both; FULL_p stays 1; cnt stays DEPTH; the head advances.
REQ-023 ENQ_p alone while full is dropped: storage, wp and cnt are unchanged.
REQ-024 DEQ_p while empty is ignored: rp and cnt are unchanged.
REQ-025 FIFO order is strict; every accepted word is output exactly once.

Reset
REQ-026 When rst=1 at a rising edge: wp=0, rp=0, cnt=0, EMPTY_p=1, FULL_p=0, COUNT_p=0, and OVF_p=UNF_p=0 if present.
REQ-027 Reset takes priority over a simultaneous ENQ_p or DEQ_p; a mid-operation reset discards all contents.
REQ-028 Storage contents are not reset; DO_p is don't-care while EMPTY_p=1.

Configuration
REQ-029 Macro GENBUF_FIFO_ERR_EN: when defined, OVF_p and UNF_p exist as ports.
REQ-030 With GENBUF_FIFO_ERR_EN, OVF_p sets on ENQ_p && FULL_p && !DEQ_p, and UNF_p sets on DEQ_p && EMPTY_p.
REQ-031 With GENBUF_FIFO_ERR_EN, each flag goes high at the next edge and holds until reset.
REQ-032 Without GENBUF_FIFO_ERR_EN, the ports and their logic are absent, and all other behaviour is identical.

Verification
REQ-033 Reset, then idle 3 cycles -> EMPTY_p=1, FULL_p=0, COUNT_p=0 throughout.
REQ-034 With DEPTH=4, enqueue 0x11,0x22,0x33,0x44 on consecutive cycles -> COUNT_p 1,2,3,4; FULL_p=1 after the 4th; DO_p=0x11.
REQ-035 From full, ENQ_p=1 with DI_p=0x55 and DEQ_p=0 -> contents unchanged; COUNT_p=4; OVF_p=1 with macro.
REQ-036 From full, ENQ_p=1 with DI_p=0x66 and DEQ_p=1 -> COUNT_p=4; DO_p=0x22; after 4 further dequeues the output sequence is 0x22,0x33,0x44,0x66 and the pointers have wrapped.
REQ-037 From empty, ENQ_p=1 with DI_p=0x77 and DEQ_p=1 -> next cycle COUNT_p=1, EMPTY_p=0, DO_p=0x77; a lone DEQ_p on empty afterwards leaves COUNT_p=0 and sets UNF_p=1 with macro.
REQ-038 Assert rst with 3 entries queued and ENQ_p=1 -> next cycle COUNT_p=0, EMPTY_p=1, flags cleared.

Source files
------------

// File: rtl/genbuf_fifo_if.sv
// genbuf_fifo_if -- handshake/data bundle for genbuf_fifo.
//   Parameters: DATA_W (word width), DEPTH_LOG2 (log2 of FIFO depth).
//   Signals   : ENQ_p, DEQ_p, DI_p     (producer/consumer -> FIFO)
//               DO_p, EMPTY_p, FULL_p, COUNT_p (FIFO -> producer/consumer)
//               OVF_p, UNF_p           (FIFO -> monitor, only with GENBUF_FIFO_ERR_EN)
//   Modports  : master (drives requests), slave (the FIFO itself).
interface genbuf_fifo_if #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 2
);
   logic                  ENQ_p;
   logic                  DEQ_p;
   logic [DATA_W-1:0]     DI_p;
   logic [DATA_W-1:0]     DO_p;
   logic                  EMPTY_p;
   logic                  FULL_p;
   logic [DEPTH_LOG2:0]   COUNT_p;
`ifdef GENBUF_FIFO_ERR_EN
   logic                  OVF_p;
   logic                  UNF_p;
`endif

`ifdef GENBUF_FIFO_ERR_EN
   modport master (
      output ENQ_p, DEQ_p, DI_p,
      input  DO_p, EMPTY_p, FULL_p, COUNT_p, OVF_p, UNF_p
   );
   modport slave (
      input  ENQ_p, DEQ_p, DI_p,
      output DO_p, EMPTY_p, FULL_p, COUNT_p, OVF_p, UNF_p
   );
`else
   modport master (
      output ENQ_p, DEQ_p, DI_p,
      input  DO_p, EMPTY_p, FULL_p, COUNT_p
   );
   modport slave (
      input  ENQ_p, DEQ_p, DI_p,
      output DO_p, EMPTY_p, FULL_p, COUNT_p
   );
`endif
endinterface

// File: rtl/genbuf_fifo.sv
// genbuf_fifo -- synchronous first-word-fall-through FIFO, DEPTH = 2**DEPTH_LOG2.
//   clk : single clock, all state changes on rising edge
//   rst : synchronous active-high reset (pointers, count, flags; storage is not cleared)
//   bus : genbuf_fifo_if.slave
//         ENQ_p/DI_p  enqueue request and data (accepted when not full, or full with DEQ_p)
//         DEQ_p       dequeue request (accepted when not empty)
//         DO_p        head word, valid while EMPTY_p = 0
//         EMPTY_p, FULL_p, COUNT_p  registered occupancy status
//   Optional macro GENBUF_FIFO_ERR_EN adds sticky OVF_p (enqueue dropped while full)
//   and UNF_p (dequeue while empty) flags, cleared only by reset.
module genbuf_fifo #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input logic         clk,
   input logic         rst,
   genbuf_fifo_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp;
   logic [DEPTH_LOG2-1:0] rp;
   logic [DEPTH_LOG2:0]   cnt;
   logic [DEPTH_LOG2:0]   cntNext;
   logic                  emptyR;
   logic                  fullR;
   logic                  enqOk;
   logic                  deqOk;

   // Acceptance uses the registered flags, so a simultaneous enq/deq on an
   // empty FIFO only enqueues, and on a full FIFO does both.
   always_comb begin
      enqOk   = bus.ENQ_p && (!fullR || bus.DEQ_p);
      deqOk   = bus.DEQ_p && !emptyR;
      cntNext = cnt;
      case ({enqOk, deqOk})
         2'b10:   cntNext = cnt + 1'b1;
         2'b01:   cntNext = cnt - 1'b1;
         default: cntNext = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         emptyR <= 1'b1;
         fullR  <= 1'b0;
      end else begin
         if (enqOk) wp <= wp + 1'b1;
         if (deqOk) rp <= rp + 1'b1;
         cnt    <= cntNext;
         // Flags are registered from the next count so they match COUNT_p
         // after the edge without any path from the request inputs.
         emptyR <= (cntNext == '0);
         fullR  <= (cntNext == (DEPTH_LOG2+1)'(DEPTH));
      end
   end

   // Storage has no reset; gating by rst keeps a reset cycle from writing.
   always_ff @(posedge clk) begin
      if (!rst && enqOk) mem[wp] <= bus.DI_p;
   end

   assign bus.DO_p    = mem[rp];
   assign bus.EMPTY_p = emptyR;
   assign bus.FULL_p  = fullR;
   assign bus.COUNT_p = cnt;

`ifdef GENBUF_FIFO_ERR_EN
   logic ovfR;
   logic unfR;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovfR <= 1'b0;
         unfR <= 1'b0;
      end else begin
         if (bus.ENQ_p && fullR && !bus.DEQ_p) ovfR <= 1'b1;
         if (bus.DEQ_p && emptyR)              unfR <= 1'b1;
      end
   end

   assign bus.OVF_p = ovfR;
   assign bus.UNF_p = unfR;
`endif
endmodule

// File: tb/tb_genbuf_fifo.sv
// tb_genbuf_fifo -- directed self-checking bench for genbuf_fifo (DATA_W=32, DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_genbuf_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned nTests = 0;
   int unsigned nFail  = 0;

   genbuf_fifo_if #(.DATA_W(32), .DEPTH_LOG2(2)) bus ();

   genbuf_fifo #(.DATA_W(32), .DEPTH_LOG2(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic enq, input logic deq, input logic [31:0] di);
      bus.ENQ_p = enq;
      bus.DEQ_p = deq;
      bus.DI_p  = di;
   endtask

   logic [31:0] pushVals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   logic [31:0] popVals  [4] = '{32'h22, 32'h33, 32'h44, 32'h66};

   initial begin
      drive(1'b0, 1'b0, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_empty", {31'b0, bus.EMPTY_p}, 32'd1);
      chk("rst_full",  {31'b0, bus.FULL_p},  32'd0);
      chk("rst_count", {29'b0, bus.COUNT_p}, 32'd0);
`ifdef GENBUF_FIFO_ERR_EN
      chk("rst_ovf", {31'b0, bus.OVF_p}, 32'd0);
      chk("rst_unf", {31'b0, bus.UNF_p}, 32'd0);
`endif

      // Idle three cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_empty", {31'b0, bus.EMPTY_p}, 32'd1);
         chk("idle_full",  {31'b0, bus.FULL_p},  32'd0);
         chk("idle_count", {29'b0, bus.COUNT_p}, 32'd0);
      end

      // Fill to DEPTH
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, pushVals[i]);
         step();
         chk("fill_count", {29'b0, bus.COUNT_p}, 32'(i + 1));
         chk("fill_head",  bus.DO_p, 32'h11);
         chk("fill_empty", {31'b0, bus.EMPTY_p}, 32'd0);
      end
      chk("fill_full", {31'b0, bus.FULL_p}, 32'd1);

      // Enqueue alone while full is dropped
      drive(1'b1, 1'b0, 32'h55);
      step();
      chk("ovf_count", {29'b0, bus.COUNT_p}, 32'd4);
      chk("ovf_full",  {31'b0, bus.FULL_p},  32'd1);
      chk("ovf_head",  bus.DO_p, 32'h11);
`ifdef GENBUF_FIFO_ERR_EN
      chk("ovf_flag", {31'b0, bus.OVF_p}, 32'd1);
`endif

      // Enqueue + dequeue while full does both
      drive(1'b1, 1'b1, 32'h66);
      step();
      chk("fulboth_count", {29'b0, bus.COUNT_p}, 32'd4);
      chk("fulboth_full",  {31'b0, bus.FULL_p},  32'd1);
      chk("fulboth_head",  bus.DO_p, 32'h22);

      // Drain: order proves the dropped 0x55 never landed and pointers wrapped
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", bus.DO_p, popVals[i]);
         drive(1'b0, 1'b1, '0);
         step();
         chk("drain_count", {29'b0, bus.COUNT_p}, 32'(3 - i));
         chk("drain_full",  {31'b0, bus.FULL_p},  32'd0);
      end
      chk("drain_empty", {31'b0, bus.EMPTY_p}, 32'd1);

      // Enqueue + dequeue while empty: enqueue only
      drive(1'b1, 1'b1, 32'h77);
      step();
      chk("empboth_count", {29'b0, bus.COUNT_p}, 32'd1);
      chk("empboth_empty", {31'b0, bus.EMPTY_p}, 32'd0);
      chk("empboth_head",  bus.DO_p, 32'h77);

      // Pop 0x77, then a dequeue on empty
      drive(1'b0, 1'b1, '0);
      step();
      chk("pop77_count", {29'b0, bus.COUNT_p}, 32'd0);
      chk("pop77_empty", {31'b0, bus.EMPTY_p}, 32'd1);
      drive(1'b0, 1'b1, '0);
      step();
      chk("unf_count", {29'b0, bus.COUNT_p}, 32'd0);
      chk("unf_empty", {31'b0, bus.EMPTY_p}, 32'd1);
`ifdef GENBUF_FIFO_ERR_EN
      chk("unf_flag", {31'b0, bus.UNF_p}, 32'd1);
      chk("ovf_sticky", {31'b0, bus.OVF_p}, 32'd1);
`endif

      // rp untouched by the ignored dequeue: next word comes out directly
      drive(1'b1, 1'b0, 32'h88);
      step();
      chk("after_unf_head",  bus.DO_p, 32'h88);
      drive(1'b1, 1'b0, 32'h99);
      step();
      drive(1'b1, 1'b0, 32'hAA);
      step();
      chk("pre_rst_count", {29'b0, bus.COUNT_p}, 32'd3);
      chk("pre_rst_head",  bus.DO_p, 32'h88);

      // Reset beats a simultaneous enqueue
      rst = 1'b1;
      drive(1'b1, 1'b0, 32'hBB);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, '0);
      chk("midrst_count", {29'b0, bus.COUNT_p}, 32'd0);
      chk("midrst_empty", {31'b0, bus.EMPTY_p}, 32'd1);
      chk("midrst_full",  {31'b0, bus.FULL_p},  32'd0);
`ifdef GENBUF_FIFO_ERR_EN
      chk("midrst_ovf", {31'b0, bus.OVF_p}, 32'd0);
      chk("midrst_unf", {31'b0, bus.UNF_p}, 32'd0);
`endif

      // Fresh start after reset
      drive(1'b1, 1'b0, 32'hCC);
      step();
      drive(1'b0, 1'b0, '0);
      chk("post_rst_count", {29'b0, bus.COUNT_p}, 32'd1);
      chk("post_rst_head",  bus.DO_p, 32'hCC);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
